temp_avg_filter: RTL and testbench
==================================

// Module: temp_avg_filter
// PURPOSE
//  Moving-average filter between the temperature sensor controller and the temperature display stage.
//  Accepts 13-bit two's-complement samples (4 fractional bits) with a one-cycle valid strobe.
//  Keeps a 2**LOG2_N-deep sample ring and emits the smoothed temperature for display.
//  Also tracks the minimum and maximum filtered value since reset/clear.
// PARAMETERS
//  TEMP_W  13  sample width, two's complement, 4 fractional bits
//  LOG2_N  3   log2 of averaging depth (N = 8 samples)
// PORTS
//  clk           in   1        system clock, single clock domain
//  rst           in   1        synchronous, active-high reset
//  sample_in     in   TEMP_W   raw temperature sample
//  sample_valid  in   1        one-cycle strobe: sample_in valid this cycle
//  hold          in   1        1 = freeze: drop incoming samples, outputs unchanged
//  clear         in   1        1-cycle: flush ring, return to EMPTY, min/max to 0
//  temp_avg      out  TEMP_W   filtered temperature, registered
//  avg_valid     out  1        one-cycle pulse when temp_avg updates
//  temp_min      out  TEMP_W   lowest temp_avg since reset/clear
//  temp_max      out  TEMP_W   highest temp_avg since reset/clear
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=EMPTY, wr_ptr=0, sum=0, ring=0.
//    Outputs at reset: temp_avg=0, avg_valid=0, temp_min=0, temp_max=0.
//  - accept = sample_valid & ~hold & ~clear. Samples that are not accepted are dropped, not queued.
//  - FSM states: EMPTY, RUN.
//    EMPTY --accept--> RUN. RUN --clear--> EMPTY. Any state --rst--> EMPTY.
//  - EMPTY accept: every ring entry <= sample_in; sum <= sample_in <<< LOG2_N; wr_ptr <= 1.
//    Result: temp_avg=sample_in, temp_min=temp_max=sample_in.
//  - RUN accept: ring[wr_ptr] <= sample_in; sum <= sum + sample_in - ring[wr_ptr];
//    wr_ptr <= wr_ptr+1, wrapping modulo N (7 -> 0).
//  - Arithmetic: sample_in is sign-extended before any add. sum is signed, TEMP_W+LOG2_N bits (16).
//    Overflow is impossible by construction.
//  - temp_avg = next_sum >>> LOG2_N (arithmetic shift, rounds toward -inf), truncated to TEMP_W bits.
//  - Latency: accept in cycle t -> temp_avg/avg_valid visible in cycle t+1. avg_valid is high exactly 1 cycle.
//  - Back-to-back accepts every cycle are supported at full rate.
//  - Min/max: on each RUN update, temp_min <= min(temp_min, new avg) and temp_max <= max(temp_max, new avg).
//    Comparison is signed.
//  - clear: state=EMPTY, sum=0, wr_ptr=0, temp_min=temp_max=0, avg_valid=0.
//    temp_avg keeps its last value until the next accept.
//    clear with sample_valid in the same cycle: clear wins, sample dropped.
//  - hold=1: no state change at all. avg_valid=0 and min/max frozen.
//    Clear still acts while hold=1.
//  - rst takes priority over clear, hold and sample_valid. Reset mid-operation discards the ring contents.
// STRUCTURE
//  - Package tfilt_pkg: TEMP_W, LOG2_N defaults, typedef temp_t (logic signed [TEMP_W-1:0]),
//    typedef enum {EMPTY, RUN} tfilt_state_t.
//  - Sub-module tavg_ring: N x TEMP_W register ring. Ports: write pointer, single write,
//    preload-all, read of the oldest entry.
//  - Top level holds the FSM, the running-sum accumulator and the min/max registers.
// TESTING
//  1 Reset, then one sample 0x190 (25.0C) -> next cycle temp_avg=0x190, avg_valid=1 for 1 cycle,
//    min=max=0x190.
//  2 After 1, eight samples 0x1A0 -> temp_avg=0x192,0x194,...,0x1A0; min=0x190, max=0x1A0.
//  3 First sample 0x1FEF (-1.0625C), then 4x 0x0000 -> sum=-68, temp_avg=0x1FF7 (floor of -8.5 = -9);
//    temp_min=0x1FEF.
//  4 Extremes: preload 0x0FFF, then 8x 0x1000 -> no overflow, final temp_avg=0x1000.
//  5 hold=1 with 3 strobes -> avg_valid stays 0, temp_avg unchanged.
//    Then clear together with sample_valid -> sample dropped, min/max=0.
//    Next sample preloads the ring.
//  6 rst asserted mid-stream after 5 RUN samples -> all outputs 0 next cycle.
//    Next sample behaves as the first sample after reset (as in 1).

Source files
------------

// File: rtl/tfilt_pkg.sv
// Shared widths, sample type and FSM state encoding for the temperature
// moving-average filter.
package tfilt_pkg;
    localparam int TEMP_W_DEF = 13;
    localparam int LOG2_N_DEF = 3;

    typedef logic signed [TEMP_W_DEF-1:0] temp_t;

    typedef enum logic {
        EMPTY = 1'b0,
        RUN   = 1'b1
    } tfilt_state_t;
endpackage

// File: rtl/tavg_ring.sv
// N-entry sample ring: single write at the pointer, preload of every entry,
// and combinational read of the entry about to be overwritten (the oldest).
module tavg_ring #(
    parameter int TEMP_W = 13,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LOG2_N-1:0] i_wr_ptr,
    input  logic              i_wr_en,
    input  logic              i_preload,
    input  logic [TEMP_W-1:0] i_wr_data,
    output logic [TEMP_W-1:0] o_oldest
);
    localparam int N = 1 << LOG2_N;

    logic [TEMP_W-1:0] w_entries [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_entry
        logic [TEMP_W-1:0] r_entry;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_entry <= '0;
            end else if (i_preload || (i_wr_en && (i_wr_ptr == LOG2_N'(gi)))) begin
                r_entry <= i_wr_data;
            end
        end

        assign w_entries[gi] = r_entry;
    end

    assign o_oldest = w_entries[i_wr_ptr];
endmodule

// File: rtl/temp_avg_filter.sv
// Moving-average filter for signed temperature samples with running-sum
// accumulator and min/max tracking of the filtered value.
module temp_avg_filter
    import tfilt_pkg::*;
#(
    parameter int TEMP_W = TEMP_W_DEF,
    parameter int LOG2_N = LOG2_N_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TEMP_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              hold,
    input  logic              clear,
    output logic [TEMP_W-1:0] temp_avg,
    output logic              avg_valid,
    output logic [TEMP_W-1:0] temp_min,
    output logic [TEMP_W-1:0] temp_max
);
    localparam int SUM_W = TEMP_W + LOG2_N;

    tfilt_state_t             r_state, w_state_next;
    logic [LOG2_N-1:0]        r_wr_ptr;
    logic signed [SUM_W-1:0]  r_sum, w_sum_next;
    logic signed [SUM_W-1:0]  w_in_ext, w_old_ext;
    logic signed [TEMP_W-1:0] r_temp_avg, r_min, r_max, w_avg_next;
    logic [TEMP_W-1:0]        w_oldest, w_ring_data;
    logic                     r_avg_valid;
    logic                     w_accept, w_preload, w_write;

    assign w_accept    = sample_valid & ~hold & ~clear;
    // Clear flushes the ring to zero through the same preload path used by the first sample.
    assign w_preload   = clear | (w_accept & (r_state == EMPTY));
    assign w_write     = w_accept & (r_state == RUN);
    assign w_ring_data = clear ? '0 : sample_in;

    tavg_ring #(
        .TEMP_W (TEMP_W),
        .LOG2_N (LOG2_N)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_en   (w_write),
        .i_preload (w_preload),
        .i_wr_data (w_ring_data),
        .o_oldest  (w_oldest)
    );

    assign w_in_ext  = {{LOG2_N{sample_in[TEMP_W-1]}}, sample_in};
    assign w_old_ext = {{LOG2_N{w_oldest[TEMP_W-1]}}, w_oldest};

    always_comb begin
        w_state_next = r_state;
        w_sum_next   = r_sum + w_in_ext - w_old_ext;
        case (r_state)
            EMPTY: begin
                w_sum_next = {sample_in, {LOG2_N{1'b0}}};
                if (w_accept) w_state_next = RUN;
            end
            RUN: begin
                if (clear) w_state_next = EMPTY;
            end
            default: w_state_next = EMPTY;
        endcase
    end

    // Upper TEMP_W bits of the sum are the floor-divided average.
    assign w_avg_next = w_sum_next[SUM_W-1:LOG2_N];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_wr_ptr    <= '0;
            r_sum       <= '0;
            r_temp_avg  <= '0;
            r_avg_valid <= 1'b0;
            r_min       <= '0;
            r_max       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_avg_valid <= w_accept;
            if (clear) begin
                r_sum    <= '0;
                r_wr_ptr <= '0;
                r_min    <= '0;
                r_max    <= '0;
            end else if (w_accept) begin
                r_sum      <= w_sum_next;
                r_temp_avg <= w_avg_next;
                if (r_state == EMPTY) begin
                    r_wr_ptr <= LOG2_N'(1);
                    r_min    <= w_avg_next;
                    r_max    <= w_avg_next;
                end else begin
                    r_wr_ptr <= r_wr_ptr + LOG2_N'(1);
                    if (w_avg_next < r_min) r_min <= w_avg_next;
                    if (w_avg_next > r_max) r_max <= w_avg_next;
                end
            end
        end
    end

    assign temp_avg  = r_temp_avg;
    assign avg_valid = r_avg_valid;
    assign temp_min  = r_min;
    assign temp_max  = r_max;
endmodule

// File: tb/tb_temp_avg_filter.sv
// Directed, table-driven check of temp_avg_filter with hand-computed expectations.
module tb_temp_avg_filter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        hold = 1'b0;
    logic        clear = 1'b0;
    logic [12:0] temp_avg;
    logic        avg_valid;
    logic [12:0] temp_min;
    logic [12:0] temp_max;

    int n_checks = 0;
    int n_fail   = 0;
    int n_vec    = 0;

    typedef struct {
        logic        rst;
        logic        sv;
        logic        hold;
        logic        clr;
        logic [12:0] din;
        logic [12:0] e_avg;
        logic        e_val;
        logic [12:0] e_min;
        logic [12:0] e_max;
    } vec_t;

    vec_t tbl[$];

    temp_avg_filter dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .hold         (hold),
        .clear        (clear),
        .temp_avg     (temp_avg),
        .avg_valid    (avg_valid),
        .temp_min     (temp_min),
        .temp_max     (temp_max)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic v, logic h, logic c, logic [12:0] d,
                                logic [12:0] a, logic ev, logic [12:0] mn, logic [12:0] mx);
        vec_t t;
        t.rst = r; t.sv = v; t.hold = h; t.clr = c; t.din = d;
        t.e_avg = a; t.e_val = ev; t.e_min = mn; t.e_max = mx;
        return t;
    endfunction

    task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got 0x%0h required 0x%0h", n_vec, name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; sample_valid = v.sv; hold = v.hold; clear = v.clr; sample_in = v.din;
        @(posedge clk);
        #1;
        $display("vec%0d rst=%0b sv=%0b hold=%0b clr=%0b din=0x%0h -> avg=0x%0h val=%0b min=0x%0h max=0x%0h",
                 n_vec, v.rst, v.sv, v.hold, v.clr, v.din, temp_avg, avg_valid, temp_min, temp_max);
        chk("temp_avg", temp_avg, v.e_avg);
        chk("avg_valid", {12'b0, avg_valid}, {12'b0, v.e_val});
        chk("temp_min", temp_min, v.e_min);
        chk("temp_max", temp_max, v.e_max);
        n_vec++;
    endtask

    initial begin
        logic [12:0] a;
        logic [12:0] t4 [8];
        t4[0] = 13'h0BFF; t4[1] = 13'h07FF; t4[2] = 13'h03FF; t4[3] = 13'h1FFF;
        t4[4] = 13'h1BFF; t4[5] = 13'h17FF; t4[6] = 13'h13FF; t4[7] = 13'h1000;

        // Reset state, then first sample preloads the ring.
        tbl.push_back(mk(1, 0, 0, 0, 13'h000, 13'h000, 0, 13'h000, 13'h000));
        tbl.push_back(mk(0, 1, 0, 0, 13'h190, 13'h190, 1, 13'h190, 13'h190));
        tbl.push_back(mk(0, 0, 0, 0, 13'h000, 13'h190, 0, 13'h190, 13'h190));
        // Eight back-to-back samples of 0x1A0 step the average by 2 each.
        for (int k = 1; k <= 8; k++) begin
            a = 13'(13'h190 + 2 * k);
            tbl.push_back(mk(0, 1, 0, 0, 13'h1A0, a, 1, 13'h190, a));
        end
        tbl.push_back(mk(0, 0, 0, 0, 13'h000, 13'h1A0, 0, 13'h190, 13'h1A0));
        // Negative first sample then zeros: floor rounding toward -inf.
        tbl.push_back(mk(0, 0, 0, 1, 13'h000, 13'h1A0, 0, 13'h000, 13'h000));
        tbl.push_back(mk(0, 1, 0, 0, 13'h1FEF, 13'h1FEF, 1, 13'h1FEF, 13'h1FEF));
        tbl.push_back(mk(0, 1, 0, 0, 13'h000, 13'h1FF1, 1, 13'h1FEF, 13'h1FF1));
        tbl.push_back(mk(0, 1, 0, 0, 13'h000, 13'h1FF3, 1, 13'h1FEF, 13'h1FF3));
        tbl.push_back(mk(0, 1, 0, 0, 13'h000, 13'h1FF5, 1, 13'h1FEF, 13'h1FF5));
        tbl.push_back(mk(0, 1, 0, 0, 13'h000, 13'h1FF7, 1, 13'h1FEF, 13'h1FF7));
        // Full-scale swing from max positive to max negative.
        tbl.push_back(mk(0, 0, 0, 1, 13'h000, 13'h1FF7, 0, 13'h000, 13'h000));
        tbl.push_back(mk(0, 1, 0, 0, 13'h0FFF, 13'h0FFF, 1, 13'h0FFF, 13'h0FFF));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 1, 0, 0, 13'h1000, t4[k], 1, t4[k], 13'h0FFF));

        foreach (tbl[i]) apply(tbl[i]);

        // Hold drops strobes; clear beats a simultaneous strobe; next sample preloads.
        for (int k = 0; k < 3; k++)
            apply(mk(0, 1, 1, 0, 13'h100, 13'h1000, 0, 13'h1000, 13'h0FFF));
        apply(mk(0, 1, 0, 1, 13'h050, 13'h1000, 0, 13'h000, 13'h000));
        apply(mk(0, 0, 0, 0, 13'h000, 13'h1000, 0, 13'h000, 13'h000));
        apply(mk(0, 1, 0, 0, 13'h080, 13'h080, 1, 13'h080, 13'h080));
        apply(mk(0, 1, 0, 0, 13'h100, 13'h090, 1, 13'h080, 13'h090));
        // Clear still acts while hold is high.
        apply(mk(0, 1, 1, 1, 13'h300, 13'h090, 0, 13'h000, 13'h000));
        apply(mk(0, 1, 0, 0, 13'h020, 13'h020, 1, 13'h020, 13'h020));

        // Reset mid-stream after five RUN samples, then restart as after power-up.
        for (int k = 1; k <= 5; k++) begin
            a = 13'(13'h020 + 8 * k);
            apply(mk(0, 1, 0, 0, 13'h060, a, 1, 13'h020, a));
        end
        apply(mk(1, 1, 0, 0, 13'h300, 13'h000, 0, 13'h000, 13'h000));
        apply(mk(0, 1, 0, 0, 13'h190, 13'h190, 1, 13'h190, 13'h190));
        apply(mk(0, 1, 0, 0, 13'h1A0, 13'h192, 1, 13'h190, 13'h192));
        apply(mk(0, 0, 0, 0, 13'h000, 13'h192, 0, 13'h190, 13'h192));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
